// File: rtl/jpeg_commit_fifo_if.sv
// jpeg_commit_fifo_if: write/read/transaction bus of the commit FIFO
interface jpeg_commit_fifo_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic [WIDTH-1:0]  data_in_i;
  logic              push_i;
  logic              pop_i;
  logic              flush_i;
  logic              commit_i;
  logic              rollback_i;
  logic [WIDTH-1:0]  data_out_o;
  logic              accept_o;
  logic              valid_o;
  logic [ADDR_W:0]   level_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;
  modport master (
    output data_in_i, push_i, pop_i, flush_i, commit_i, rollback_i,
    input  data_out_o, accept_o, valid_o, level_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );
  modport slave (
    input  data_in_i, push_i, pop_i, flush_i, commit_i, rollback_i,
    output data_out_o, accept_o, valid_o, level_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/jpeg_commit_fifo.sv
// jpeg_commit_fifo: FWFT FIFO whose writes become visible only on commit and can be rolled back
module jpeg_commit_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  jpeg_commit_fifo_if.slave  bus
);
  localparam int PW = ADDR_W + 1;
  logic [WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0] wr_q, cm_q, rd_q, wr_d, cm_d, rd_d, wr_adv, total, committed;
  logic ovf_q, unf_q, ovf_d, unf_d, push_ok, pop_ok;
  always_comb begin
    total     = wr_q - rd_q;
    committed = cm_q - rd_q;
    push_ok   = bus.push_i & bus.accept_o;
    pop_ok    = bus.pop_i & bus.valid_o;
    wr_adv    = wr_q + PW'(push_ok);
    // commit beats rollback; a push under rollback is dropped with the rest of the pending data
    wr_d  = bus.flush_i ? '0 : bus.commit_i ? wr_adv : bus.rollback_i ? cm_q : wr_adv;
    cm_d  = bus.flush_i ? '0 : bus.commit_i ? wr_adv : cm_q;
    rd_d  = bus.flush_i ? '0 : rd_q + PW'(pop_ok);
    ovf_d = ~bus.flush_i & (ovf_q | (bus.push_i & ~bus.accept_o));
    unf_d = ~bus.flush_i & (unf_q | (bus.pop_i & ~bus.valid_o));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      cm_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      cm_q  <= cm_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) ram[wr_q[ADDR_W-1:0]] <= bus.data_in_i;
  end
  assign bus.data_out_o     = ram[rd_q[ADDR_W-1:0]];
  assign bus.accept_o       = total != PW'(DEPTH);
  assign bus.valid_o        = committed != '0;
  assign bus.level_o        = committed;
  assign bus.almost_full_o  = total >= PW'(AFULL_LVL);
  assign bus.almost_empty_o = committed <= PW'(AEMPTY_LVL);
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_jpeg_commit_fifo.sv
// tb_jpeg_commit_fifo: directed + random checks against a committed/pending queue model
module tb_jpeg_commit_fifo;
  localparam int W = 8, D = 16, A = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  jpeg_commit_fifo_if #(.WIDTH(W), .ADDR_W(A)) bus ();
  jpeg_commit_fifo #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .AFULL_LVL(12), .AEMPTY_LVL(2))
    dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  logic [W-1:0] cq[$], pq[$];
  bit m_ovf, m_unf;
  int total = 0, bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(string tag);
    int t = cq.size() + pq.size();
    chk({tag, ".accept"}, 32'(bus.accept_o), 32'(t != D));
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(cq.size() != 0));
    chk({tag, ".level"}, 32'(bus.level_o), 32'(cq.size()));
    chk({tag, ".afull"}, 32'(bus.almost_full_o), 32'(t >= 12));
    chk({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(cq.size() <= 2));
    chk({tag, ".ovf"}, 32'(bus.overflow_o), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.underflow_o), 32'(m_unf));
    if (cq.size() != 0) chk({tag, ".data"}, 32'(bus.data_out_o), 32'(cq[0]));
  endtask
  task automatic model_reset();
    cq.delete();
    pq.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic cyc(string tag, bit p, bit o, bit c, bit r, bit f, logic [W-1:0] d);
    bit acc, val;
    bus.push_i = p; bus.pop_i = o; bus.commit_i = c;
    bus.rollback_i = r; bus.flush_i = f; bus.data_in_i = d;
    @(posedge clk);
    acc = (cq.size() + pq.size()) != D;
    val = cq.size() != 0;
    if (f) model_reset();
    else begin
      if (p && !acc) m_ovf = 1;
      if (o && !val) m_unf = 1;
      if (o && val) void'(cq.pop_front());
      if (p && acc) pq.push_back(d);
      if (c) begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
      end else if (r) pq.delete();
    end
    #1;
    check_all(tag);
  endtask
  initial begin
    bus.push_i = 0; bus.pop_i = 0; bus.commit_i = 0;
    bus.rollback_i = 0; bus.flush_i = 0; bus.data_in_i = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    // staged writes stay invisible until commit
    cyc("s1p", 1, 0, 0, 0, 0, 8'h11);
    cyc("s1p", 1, 0, 0, 0, 0, 8'h22);
    cyc("s1p", 1, 0, 0, 0, 0, 8'h33);
    chk("s1_level_pre", 32'(bus.level_o), 0);
    cyc("s1c", 0, 0, 1, 0, 0, 8'h00);
    chk("s1_level", 32'(bus.level_o), 3);
    chk("s1_data", 32'(bus.data_out_o), 32'h11);
    // rollback discards only the uncommitted tail
    cyc("s2f", 0, 0, 0, 0, 1, 8'h00);
    cyc("s2p", 1, 0, 0, 0, 0, 8'h11);
    cyc("s2pc", 1, 0, 1, 0, 0, 8'h22);
    for (int i = 0; i < 3; i++) cyc("s2p", 1, 0, 0, 0, 0, 8'(8'hA0 + i));
    cyc("s2r", 0, 0, 0, 1, 0, 8'h00);
    chk("s2_level", 32'(bus.level_o), 2);
    cyc("s2pc", 1, 0, 1, 0, 0, 8'h44);
    chk("s2_d0", 32'(bus.data_out_o), 32'h11);
    cyc("s2pop", 0, 1, 0, 0, 0, 8'h00);
    chk("s2_d1", 32'(bus.data_out_o), 32'h22);
    cyc("s2pop", 0, 1, 0, 0, 0, 8'h00);
    chk("s2_d2", 32'(bus.data_out_o), 32'h44);
    cyc("s2pop", 0, 1, 0, 0, 0, 8'h00);
    // fill, overflow, flush
    for (int i = 0; i < D; i++) cyc("s3p", 1, 0, i == D - 1, 0, 0, 8'(i + 1));
    chk("s3_accept", 32'(bus.accept_o), 0);
    chk("s3_afull", 32'(bus.almost_full_o), 1);
    cyc("s3ovf", 1, 1, 0, 0, 0, 8'hEE);
    chk("s3_ovf", 32'(bus.overflow_o), 1);
    chk("s3_intact", 32'(bus.data_out_o), 2);
    cyc("s3f", 0, 0, 0, 0, 1, 8'h00);
    chk("s3_ovf_clr", 32'(bus.overflow_o), 0);
    // underflow and wrap-around streaming
    cyc("s4unf", 0, 1, 0, 0, 0, 8'h00);
    chk("s4_unf", 32'(bus.underflow_o), 1);
    for (int i = 0; i < 40; i++) cyc("s4s", 1, i >= 3, 1, 0, 0, 8'(8'h50 + i));
    for (int i = 0; i < 4; i++) cyc("s4d", 0, 1, 0, 0, 0, 8'h00);
    // commit beats rollback; rollback alone drops the same-cycle push
    cyc("s5f", 0, 0, 0, 0, 1, 8'h00);
    cyc("s5cr", 1, 0, 1, 1, 0, 8'h77);
    chk("s5_level", 32'(bus.level_o), 1);
    cyc("s5r", 1, 0, 0, 1, 0, 8'h88);
    cyc("s5c", 0, 0, 1, 0, 0, 8'h00);
    chk("s5_level2", 32'(bus.level_o), 1);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc("rnd", $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 2, 8'($urandom));
    // async reset mid-burst, observed before the next edge
    for (int i = 0; i < 5; i++) cyc("s6p", 1, 0, i == 2, 0, 0, 8'(8'hC0 + i));
    bus.push_i = 1;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    bus.push_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post", 1, 0, 1, 0, 0, 8'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
